// File: rtl/calc_pkg.sv
// Shared keypad/calculator definitions: FSM states, command codes and the key map,
// used by both the keypad RTL and its bench so codes can never drift apart.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_SCAN         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_EMIT         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } keypad_state_t;

  localparam logic [3:0] CMD_ADD  = 4'b1011;
  localparam logic [3:0] CMD_SUB  = 4'b1100;
  localparam logic [3:0] CMD_MUL  = 4'b1010;
  localparam logic [3:0] CMD_BACK = 4'b1101;
  localparam logic [3:0] CMD_EQ   = 4'b1110;
  localparam logic [3:0] CMD_IDLE = 4'b1111;

  // Unmapped position (row 3, column 3) returns CMD_IDLE, which the scanner ignores.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = CMD_ADD;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = CMD_SUB;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = CMD_MUL;
      4'd12:   code = CMD_BACK;
      4'd13:   code = 4'd0;
      4'd14:   code = CMD_EQ;
      default: code = CMD_IDLE;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/calc_keypad_debounce.sv
// Stable-count comparator: counts consecutive cycles with match high and
// saturates at STABLE_CYCLES; any miss or clear restarts the count.
module keypad_debounce #(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic match,
  output logic stable
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] TARGET = CW'(STABLE_CYCLES);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset || clear || !match) begin
      cnt_q <= '0;
    end else if (cnt_q != TARGET) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign stable = (cnt_q == TARGET);

endmodule

// File: rtl/calc_keypad.sv
// 4x4 calculator keypad scanner: column scan, debounce, timed command pulse.
// Optional auto-repeat for held digit keys when KEYPAD_REPEAT_EN is defined.
module calc_keypad
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CMD_HOLD_CYCLES = 10
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 50000
`endif
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    row_in,
  output logic [3:0]    col_out,
  output logic [3:0]    cmd,
  output logic          busy,
  output keypad_state_t state_dbg
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(CMD_HOLD_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CMD_HOLD_CYCLES - 1);

  keypad_state_t state_q, state_d;
  logic [1:0]    col_idx_q;
  logic [SW-1:0] scan_cnt_q;
  logic [HW-1:0] hold_cnt_q;
  logic [3:0]    cap_rows_q;
  logic [3:0]    cap_code_q;
  logic [3:0]    cmd_d;
  logic [3:0]    sample_code;
  logic          scan_last, hold_last;
  logic          db_clear, db_match, db_stable;
  logic          rep_fire;

  assign scan_last   = (scan_cnt_q == SCAN_LAST);
  assign hold_last   = (hold_cnt_q == HOLD_LAST);
  assign sample_code = key_code(lowest_low_row(row_in), col_idx_q);
  assign state_dbg   = state_q;

  // One comparator serves both waits: press stability, then full release.
  always_comb begin
    db_clear = 1'b1;
    db_match = 1'b0;
    case (state_q)
      ST_DEBOUNCE: begin
        db_clear = 1'b0;
        db_match = (row_in == cap_rows_q);
      end
      ST_WAIT_RELEASE: begin
        db_clear = 1'b0;
        db_match = (row_in == 4'hF);
      end
      default: ;
    endcase
  end

  keypad_debounce #(
    .STABLE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .clear (db_clear),
    .match (db_match),
    .stable(db_stable)
  );

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_TARGET = RW'(REPEAT_CYCLES);

  logic [RW-1:0] rep_cnt_q;

  always_ff @(posedge clock) begin
    if (reset || state_q != ST_WAIT_RELEASE || row_in != cap_rows_q) begin
      rep_cnt_q <= '0;
    end else if (rep_cnt_q != REP_TARGET) begin
      rep_cnt_q <= rep_cnt_q + RW'(1);
    end
  end

  assign rep_fire = (rep_cnt_q == REP_TARGET) && is_digit(cap_code_q);
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_SCAN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SCAN:
        if (scan_last && row_in != 4'hF && sample_code != CMD_IDLE) state_d = ST_DEBOUNCE;
      ST_DEBOUNCE:
        if (db_stable)      state_d = ST_EMIT;
        else if (!db_match) state_d = ST_SCAN;
      ST_EMIT:
        if (hold_last)      state_d = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE:
        if (db_stable)      state_d = ST_SCAN;
        else if (rep_fire)  state_d = ST_EMIT;
      default:              state_d = ST_SCAN;
    endcase
  end

  // cmd is registered from the next state so it is valid exactly while in EMIT.
  always_comb begin
    busy    = (state_q != ST_SCAN);
    col_out = ~(4'b0001 << col_idx_q);
    cmd_d   = (state_d == ST_EMIT) ? cap_code_q : CMD_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) cmd <= CMD_IDLE;
    else       cmd <= cmd_d;
  end

  // Column stays frozen once a key is captured; leaving any busy state moves on.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_idx_q  <= '0;
      scan_cnt_q <= '0;
      cap_rows_q <= 4'hF;
      cap_code_q <= CMD_IDLE;
    end else if (state_q == ST_SCAN) begin
      if (scan_last) begin
        scan_cnt_q <= '0;
        if (state_d == ST_DEBOUNCE) begin
          cap_rows_q <= row_in;
          cap_code_q <= sample_code;
        end else begin
          col_idx_q <= col_idx_q + 2'd1;
        end
      end else begin
        scan_cnt_q <= scan_cnt_q + SW'(1);
      end
    end else if (state_d == ST_SCAN) begin
      col_idx_q <= col_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || state_q != ST_EMIT) begin
      hold_cnt_q <= '0;
    end else if (!hold_last) begin
      hold_cnt_q <= hold_cnt_q + HW'(1);
    end
  end

endmodule

// File: tb/tb_calc_keypad.sv
// Directed bench for calc_keypad: a keypad model drives rows from col_out, a
// cmd monitor scores each emission (code and length) against an expected queue.
module tb_calc_keypad;
  import calc_pkg::*;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int CMD_HOLD_CYCLES = 10;
`ifdef KEYPAD_REPEAT_EN
  localparam int REPEAT_CYCLES   = 30;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    row_in;
  logic [3:0]    col_out;
  logic [3:0]    cmd;
  logic          busy;
  keypad_state_t state_dbg;

  logic [3:0] pressed [4];
  logic [3:0] exp_q[$];
  int n_checks   = 0;
  int n_errors   = 0;
  int emit_count = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  calc_keypad #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CMD_HOLD_CYCLES(CMD_HOLD_CYCLES)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .cmd      (cmd),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  initial begin
    int run_len;
    logic [3:0] run_code;
    logic [3:0] exp_code;
    run_len  = 0;
    run_code = 4'hF;
    forever begin
      @(negedge clock);
      if (reset) begin
        run_len = 0;
      end else if (cmd !== 4'hF) begin
        if (run_len == 0) run_code = cmd;
        else if (cmd !== run_code) check("cmd_steady", cmd, run_code);
        run_len++;
      end else if (run_len > 0) begin
        emit_count++;
        if (exp_q.size() == 0) begin
          check("cmd_unexpected", run_code, 4'hF);
        end else begin
          exp_code = exp_q.pop_front();
          check("cmd_code", run_code, exp_code);
        end
        check("cmd_hold_len", run_len, CMD_HOLD_CYCLES);
        run_len = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
  endtask

  // Returns at a falling edge; the next rising edge is the first out of reset.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    release_all();
    repeat (2) @(posedge clock);
    #1;
    check("rst_cmd", cmd, 4'hF);
    check("rst_col", col_out, 4'b1110);
    check("rst_busy", busy, 1'b0);
    check("rst_state", 32'(state_dbg), 32'(ST_SCAN));
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press_key(input int r, input int c, input int hold);
    pressed[r][c] = 1'b1;
    tick(hold);
    pressed[r][c] = 1'b0;
    tick(30);
  endtask

  // ---------------- stimulus ----------------
  int seq_r [6] = '{1, 3, 0, 0, 1, 3};
  int seq_c [6] = '{1, 1, 3, 0, 1, 2};
  logic [3:0] seq_code [6] = '{4'd5, 4'd0, 4'b1011, 4'd1, 4'd5, 4'b1110};

  initial begin
    int base;
    logic [3:0] expc;
    release_all();

    // Idle scan: each column low for 4 cycles, rotating 0..3.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      expc = 4'hF;
      expc[(k / 4) % 4] = 1'b0;
      check("scan_col", col_out, expc);
      check("scan_cmd", cmd, 4'hF);
      check("scan_busy", busy, 1'b0);
    end

    // Key 5 held: sampled on edge 8, cmd=5 on cycles 17..26, release done at edge 49.
    do_reset();
    base = emit_count;
    pressed[1][1] = 1'b1;
    exp_q.push_back(4'd5);
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      check("k5_cmd", cmd, (k >= 17 && k <= 26) ? 4'd5 : 4'hF);
      check("k5_busy", busy, k >= 8);
    end
    pressed[1][1] = 1'b0;
    for (int k = 41; k <= 50; k++) begin
      tick(1);
      check("k5_rel_busy", busy, k < 49);
      check("k5_rel_col", col_out, (k < 49) ? 4'b1101 : 4'b1011);
    end
    check("k5_emits", emit_count - base, 1);

    // Keyed sequence 5, 0, add, 1, 5, equals.
    do_reset();
    base = emit_count;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(seq_code[i]);
      press_key(seq_r[i], seq_c[i], 60);
    end
    check("seq_emits", emit_count - base, 6);
    check("seq_queue", exp_q.size(), 0);

    // Press bounce: released after 3 debounce matches, scan moves to column 1.
    do_reset();
    base = emit_count;
    pressed[0][0] = 1'b1;
    tick(5);
    check("bnc_busy", busy, 1'b1);
    tick(2);
    pressed[0][0] = 1'b0;
    tick(1);
    check("bnc_idle", busy, 1'b0);
    check("bnc_col", col_out, 4'b1101);
    tick(40);
    check("bnc_emits", emit_count - base, 0);

    // Release bounce: one command only.
    do_reset();
    base = emit_count;
    pressed[0][0] = 1'b1;
    exp_q.push_back(4'd1);
    tick(30);
    pressed[0][0] = 1'b0;
    tick(4);
    pressed[0][0] = 1'b1;
    tick(3);
    check("rbnc_busy", busy, 1'b1);
    pressed[0][0] = 1'b0;
    tick(40);
    check("rbnc_emits", emit_count - base, 1);
    check("rbnc_idle", busy, 1'b0);

    // Unmapped key (row 3, column 3) is ignored.
    do_reset();
    base = emit_count;
    pressed[3][3] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      check("unmap_busy", busy, 1'b0);
    end
    release_all();
    check("unmap_emits", emit_count - base, 0);

    // Rows 0 and 2 on column 0: lowest row wins, cmd=1 from cycle 13.
    do_reset();
    base = emit_count;
    pressed[0][0] = 1'b1;
    pressed[2][0] = 1'b1;
    exp_q.push_back(4'd1);
    tick(13);
    check("multi_cmd", cmd, 4'd1);
    tick(27);
    release_all();
    tick(30);
    check("multi_emits", emit_count - base, 1);

    // Reset on the 5th EMIT cycle drops the command at the next edge.
    do_reset();
    base = emit_count;
    pressed[0][0] = 1'b1;
    pressed[2][0] = 1'b1;
    tick(17);
    check("mid_emit_cmd", cmd, 4'd1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_cmd", cmd, 4'hF);
    check("mid_rst_col", col_out, 4'b1110);
    check("mid_rst_busy", busy, 1'b0);
    release_all();
    @(negedge clock);
    reset = 1'b0;
    tick(20);
    check("mid_rst_emits", emit_count - base, 0);

`ifdef KEYPAD_REPEAT_EN
    // Digit 7 held 100 cycles: emissions start at cycles 13, 54 and 95.
    do_reset();
    base = emit_count;
    pressed[2][0] = 1'b1;
    repeat (3) exp_q.push_back(4'd7);
    tick(100);
    release_all();
    tick(40);
    check("rep7_emits", emit_count - base, 3);

    // Equals never repeats.
    do_reset();
    base = emit_count;
    pressed[3][2] = 1'b1;
    exp_q.push_back(4'b1110);
    tick(100);
    release_all();
    tick(40);
    check("rep_eq_emits", emit_count - base, 1);
`endif

    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
